// File: rtl/matrix_sequencer.sv
// Job sequencer: qualifies a held start request, then steps through NUM_STAGES
// processing stages with a per-stage watchdog, reporting COMPLETE or ERROR.
module matrix_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int START_HOLD = 10,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_process,
    input  logic                  stage_finish,
    input  logic                  abort,
    input  logic                  clear,
    output logic [2:0]            status,
    output logic [3:0]            stage_idx,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic                  done,
    output logic                  timeout_err,
    output logic [7:0]            run_count
);

    typedef enum logic [2:0] {
        S_PREPARE  = 3'b000,
        S_RUN      = 3'b001,
        S_COMPLETE = 3'b011,
        S_ERROR    = 3'b100
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_STAGES - 1);
    localparam logic [9:0]  HOLD_MAX = 10'(START_HOLD);
    localparam logic [16:0] TO_LIM   = 17'(TIMEOUT);
    localparam logic        WD_EN    = (TIMEOUT != 0);

    state_t                  state_q, state_d;
    logic [9:0]              hold_q, hold_d;
    logic [15:0]             wd_q, wd_d;
    logic [3:0]              idx_q, idx_d;
    logic [NUM_STAGES-1:0]   go_q, go_d;
    logic [NUM_STAGES-1:0]   act_q, act_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [7:0]              rc_q, rc_d;
    logic                    wd_hit;

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [3:0] i);
        return NUM_STAGES'(1) << i;
    endfunction

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wd_d    = wd_q;
        idx_d   = idx_q;
        go_d    = '0;
        act_d   = act_q;
        rc_d    = rc_q;
        // Fires in the stage's TIMEOUT-th cycle if no finish arrives.
        wd_hit  = WD_EN && (({1'b0, wd_q} + 17'd1) == TO_LIM);

        case (state_q)
            S_PREPARE: begin
                if (!start_process) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_MAX) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                    idx_d   = '0;
                    wd_d    = '0;
                    go_d    = onehot(4'd0);
                    act_d   = onehot(4'd0);
                end else begin
                    hold_d = hold_q + 10'd1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_PREPARE;
                    hold_d  = '0;
                    idx_d   = '0;
                    wd_d    = '0;
                    act_d   = '0;
                end else if (stage_finish) begin
                    wd_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COMPLETE;
                        idx_d   = '0;
                        act_d   = '0;
                        rc_d    = rc_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        go_d  = onehot(idx_q + 4'd1);
                        act_d = onehot(idx_q + 4'd1);
                    end
                end else if (wd_hit) begin
                    state_d = S_ERROR;
                    idx_d   = '0;
                    wd_d    = '0;
                    act_d   = '0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_COMPLETE, S_ERROR: begin
                if (abort || clear) begin
                    state_d = S_PREPARE;
                    hold_d  = '0;
                    idx_d   = '0;
                    wd_d    = '0;
                    act_d   = '0;
                end
            end
            default: begin
                state_d = S_PREPARE;
                hold_d  = '0;
                idx_d   = '0;
                wd_d    = '0;
                act_d   = '0;
            end
        endcase

        done_d = (state_d == S_COMPLETE);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_PREPARE;
            hold_q  <= '0;
            wd_q    <= '0;
            idx_q   <= '0;
            go_q    <= '0;
            act_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            idx_q   <= idx_d;
            go_q    <= go_d;
            act_q   <= act_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rc_q    <= rc_d;
        end
    end

    assign status       = state_q;
    assign stage_idx    = idx_q;
    assign stage_go     = go_q;
    assign stage_active = act_q;
    assign done         = done_q;
    assign timeout_err  = err_q;
    assign run_count    = rc_q;

endmodule
